wb_stage: RTL

Writeback stage of the 5-stage RISC-V pipeline and sole writer of the register file. It holds the MEM/WB pipeline register and extracts and sign/zero-extends load data. It selects between the ALU result and the load result, then drives the register file write port (RegWrite, WriteRegister, WriteData) from flops. It also flags misaligned or illegal loads, counts retired instructions, and can optionally provide write-through bypass for the ID-stage read ports.

---
 rtl/wb_stage.sv | 107 ++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load extraction and extension, register file write port,
// bad-load flag and retire counter. Define WB_BYPASS_EN for same-cycle write-through to ID reads.
module wb_stage (
    input  logic        clk,
    input  logic        r,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic        mem_RegWrite,
    input  logic        mem_MemToReg,
    input  logic [2:0]  mem_funct3,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_ALUResult,
    input  logic [31:0] mem_ReadData,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        misalign,
    output logic [31:0] retired,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    input  logic [31:0] rf_ReadData1,
    input  logic [31:0] rf_ReadData2,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2
);

    logic [1:0]  addr;
    logic [7:0]  byteLane [4];
    logic [15:0] halfLane [2];
    logic [7:0]  selByte;
    logic [15:0] selHalf;
    logic [31:0] loadData;
    logic [31:0] resultNext;
    logic        badNext;
    logic        takeNext;
    logic        retirePendingReg;

    assign addr = mem_ALUResult[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gByte
            assign byteLane[gi] = mem_ReadData[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : gHalf
            assign halfLane[gi] = mem_ReadData[16*gi +: 16];
        end
    endgenerate

    always_comb begin
        selByte  = byteLane[addr];
        selHalf  = halfLane[addr[1]];
        loadData = mem_ReadData;
        badNext  = 1'b0;
        case (mem_funct3)
            3'b000: loadData = {{24{selByte[7]}}, selByte};
            3'b100: loadData = {24'b0, selByte};
            3'b001: begin
                loadData = {{16{selHalf[15]}}, selHalf};
                badNext  = addr[0];
            end
            3'b101: begin
                loadData = {16'b0, selHalf};
                badNext  = addr[0];
            end
            3'b010: badNext = (addr != 2'b00);
            default: badNext = 1'b1;
        endcase
        // Alignment and funct3 legality only matter on the load path.
        badNext    = badNext & mem_MemToReg;
        resultNext = mem_MemToReg ? loadData : mem_ALUResult;
    end

    assign takeNext = mem_valid & ~flush;

    always_ff @(posedge clk) begin
        if (r) begin
            RegWrite         <= 1'b0;
            WriteRegister    <= 5'd0;
            WriteData        <= 32'd0;
            misalign         <= 1'b0;
            retired          <= 32'd0;
            retirePendingReg <= 1'b0;
        end else begin
            RegWrite         <= takeNext & mem_RegWrite & (mem_rd != 5'd0) & ~badNext;
            WriteRegister    <= takeNext ? mem_rd : 5'd0;
            WriteData        <= takeNext ? resultNext : 32'd0;
            misalign         <= takeNext & badNext;
            // Counts the instruction that sat in WB during the previous cycle.
            retired          <= retired + {31'd0, retirePendingReg};
            retirePendingReg <= takeNext & ~badNext;
        end
    end

`ifdef WB_BYPASS_EN
    assign ReadData1 = (RegWrite && WriteRegister == ReadRegister1 && ReadRegister1 != 5'd0)
                       ? WriteData : rf_ReadData1;
    assign ReadData2 = (RegWrite && WriteRegister == ReadRegister2 && ReadRegister2 != 5'd0)
                       ? WriteData : rf_ReadData2;
`else
    logic unusedReadIdx;
    assign unusedReadIdx = ^{ReadRegister1, ReadRegister2};
    assign ReadData1 = rf_ReadData1;
    assign ReadData2 = rf_ReadData2;
`endif

endmodule
